// File: rtl/spi_cmd_decoder.sv
// Decodes the leading command byte of each SPI frame and drives coefficient RAM,
// transmit-buffer readback, the control register and the bank-commit strobe.
module spi_cmd_decoder #(
  parameter int CMD_NBITS   = 8,
  parameter int COEFF_NBITS = 24,
  parameter int ADDR_NBITS  = 6,
  parameter int BUF_NBITS   = CMD_NBITS + COEFF_NBITS
) (
  input  logic                   i_clk,
  input  logic                   i_rstn,
  input  logic                   i_frame_active,
  input  logic                   i_rx_cmd_rdy,
  input  logic                   i_rx_data_rdy,
  input  logic [BUF_NBITS-1:0]   i_rx_buf,
  output logic                   o_tx_load,
  output logic [COEFF_NBITS-1:0] o_tx_data,
  output logic                   o_coeff_we,
  output logic [ADDR_NBITS-1:0]  o_coeff_addr,
  output logic [COEFF_NBITS-1:0] o_coeff_wdata,
  input  logic [COEFF_NBITS-1:0] i_coeff_rdata,
  output logic                   o_commit,
  output logic [7:0]             o_ctrl,
  output logic                   o_busy,
  output logic [7:0]             o_err_cnt
);

  localparam logic [1:0] OP_NOP     = 2'b00;
  localparam logic [1:0] OP_WRITE   = 2'b01;
  localparam logic [1:0] OP_READ    = 2'b10;
  localparam logic [1:0] OP_SPECIAL = 2'b11;
  localparam logic [5:0] SEL_CTRL   = 6'h00;
  localparam logic [5:0] SEL_COMMIT = 6'h3F;

  typedef enum logic [2:0] {
    IDLE, CMD, RD_WAIT, RD_LOAD, DATA, EXEC, DONE
  } state_t;

  state_t state, state_next;

  logic frame_q, cmd_rdy_q, data_rdy_q;
  logic frame_rise, frame_fall, cmd_rise, data_rise;
  logic [CMD_NBITS-1:0] cmd_in, cmd_reg;
  logic latch_cmd, do_we, do_ctrl, do_commit, do_load, err_inc;

  assign cmd_in     = i_rx_buf[BUF_NBITS-1 -: CMD_NBITS];
  assign frame_rise = i_frame_active & ~frame_q;
  assign frame_fall = ~i_frame_active & frame_q;
  assign cmd_rise   = i_rx_cmd_rdy & ~cmd_rdy_q;
  assign data_rise  = i_rx_data_rdy & ~data_rdy_q;
  assign o_busy     = (state != IDLE);

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) state <= IDLE;
    else         state <= state_next;
  end

  always_comb begin
    state_next = state;
    latch_cmd  = 1'b0;
    do_we      = 1'b0;
    do_ctrl    = 1'b0;
    do_commit  = 1'b0;
    do_load    = 1'b0;
    err_inc    = 1'b0;
    case (state)
      IDLE: if (frame_rise) state_next = CMD;
      CMD: begin
        if (frame_fall) begin
          err_inc    = 1'b1;
          state_next = IDLE;
        end else if (cmd_rise) begin
          latch_cmd = 1'b1;
          case (cmd_in[CMD_NBITS-1 -: 2])
            OP_NOP:   state_next = DONE;
            OP_WRITE: state_next = DATA;
            OP_READ:  state_next = RD_WAIT;
            default: begin
              if (cmd_in[5:0] == SEL_CTRL || cmd_in[5:0] == SEL_COMMIT) begin
                state_next = DATA;
              end else begin
                err_inc    = 1'b1;
                state_next = DONE;
              end
            end
          endcase
        end
      end
      RD_WAIT: state_next = RD_LOAD;
      RD_LOAD: begin
        do_load    = 1'b1;
        state_next = DONE;
      end
      DATA: begin
        // A data_rdy rise coinciding with the frame end still executes.
        if (data_rise) begin
          state_next = EXEC;
        end else if (frame_fall) begin
          err_inc    = 1'b1;
          state_next = IDLE;
        end
      end
      EXEC: begin
        if (cmd_reg[CMD_NBITS-1 -: 2] == OP_WRITE) begin
          do_we = 1'b1;
        end else if (cmd_reg[CMD_NBITS-1 -: 2] == OP_SPECIAL) begin
          do_ctrl   = (cmd_reg[5:0] == SEL_CTRL);
          do_commit = (cmd_reg[5:0] == SEL_COMMIT);
        end
        state_next = DONE;
      end
      DONE: if (!i_frame_active) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Edge history resets high so a frame already in progress at reset release is ignored.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      frame_q       <= 1'b1;
      cmd_rdy_q     <= 1'b1;
      data_rdy_q    <= 1'b1;
      cmd_reg       <= '0;
      o_coeff_addr  <= '0;
      o_coeff_we    <= 1'b0;
      o_coeff_wdata <= '0;
      o_commit      <= 1'b0;
      o_tx_load     <= 1'b0;
      o_tx_data     <= '0;
      o_ctrl        <= 8'h01;
      o_err_cnt     <= 8'h00;
    end else begin
      frame_q    <= i_frame_active;
      cmd_rdy_q  <= i_rx_cmd_rdy;
      data_rdy_q <= i_rx_data_rdy;
      if (latch_cmd) begin
        cmd_reg      <= cmd_in;
        o_coeff_addr <= cmd_in[ADDR_NBITS-1:0];
      end
      o_coeff_we <= do_we;
      if (do_we) o_coeff_wdata <= i_rx_buf[COEFF_NBITS-1:0];
      o_commit  <= do_commit;
      o_tx_load <= do_load;
      if (do_load) o_tx_data <= i_coeff_rdata;
      if (do_ctrl) o_ctrl <= i_rx_buf[7:0];
      if (err_inc && o_err_cnt != 8'hFF) o_err_cnt <= o_err_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_spi_cmd_decoder.sv
// Directed bench for spi_cmd_decoder: frames are driven one step at a time and
// strobe counts, captured values and latencies are checked with immediate assertions.
module tb_spi_cmd_decoder;

  logic        clk = 1'b0;
  logic        rstn;
  logic        frame_active, rx_cmd_rdy, rx_data_rdy;
  logic [31:0] rx_buf;
  logic        tx_load, coeff_we, commit, busy;
  logic [23:0] tx_data, coeff_wdata, coeff_rdata;
  logic [5:0]  coeff_addr;
  logic [7:0]  ctrl, err_cnt;

  logic [23:0] mem [64];
  int cyc = 0;
  int we_cnt = 0, load_cnt = 0, commit_cnt = 0;
  int we_cyc = 0, load_cyc = 0, commit_cyc = 0;
  int cmd_cyc = 0, data_cyc = 0;
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  spi_cmd_decoder dut (
    .i_clk          (clk),
    .i_rstn         (rstn),
    .i_frame_active (frame_active),
    .i_rx_cmd_rdy   (rx_cmd_rdy),
    .i_rx_data_rdy  (rx_data_rdy),
    .i_rx_buf       (rx_buf),
    .o_tx_load      (tx_load),
    .o_tx_data      (tx_data),
    .o_coeff_we     (coeff_we),
    .o_coeff_addr   (coeff_addr),
    .o_coeff_wdata  (coeff_wdata),
    .i_coeff_rdata  (coeff_rdata),
    .o_commit       (commit),
    .o_ctrl         (ctrl),
    .o_busy         (busy),
    .o_err_cnt      (err_cnt)
  );

  // Read-only RAM model with one cycle of read latency.
  always @(posedge clk) coeff_rdata <= mem[coeff_addr];
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (coeff_we) begin we_cnt <= we_cnt + 1; we_cyc <= cyc; end
    if (tx_load)  begin load_cnt <= load_cnt + 1; load_cyc <= cyc; end
    if (commit)   begin commit_cnt <= commit_cnt + 1; commit_cyc <= cyc; end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
    $display("check %-14s observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic send_frame(input logic [7:0] c, input logic [23:0] d, input bit full);
    frame_active = 1'b1; tick(2);
    rx_buf = {c, 24'h0}; rx_cmd_rdy = 1'b1; cmd_cyc = cyc; tick(4);
    if (full) begin
      rx_buf = {c, d}; rx_data_rdy = 1'b1; data_cyc = cyc; tick(4);
    end
    frame_active = 1'b0; rx_cmd_rdy = 1'b0; rx_data_rdy = 1'b0; tick(3);
  endtask

  initial begin
    rstn = 1'b0; frame_active = 1'b0; rx_cmd_rdy = 1'b0; rx_data_rdy = 1'b0; rx_buf = '0;
    for (int i = 0; i < 64; i++) mem[i] = {18'h0, 6'(i)};
    mem[5] = 24'hABCDEF;
    tick(3);
    check("rst_tx_load", 32'(tx_load), 32'h0);
    check("rst_tx_data", 32'(tx_data), 32'h0);
    check("rst_we", 32'(coeff_we), 32'h0);
    check("rst_addr", 32'(coeff_addr), 32'h0);
    check("rst_wdata", 32'(coeff_wdata), 32'h0);
    check("rst_commit", 32'(commit), 32'h0);
    check("rst_ctrl", 32'(ctrl), 32'h01);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_err", 32'(err_cnt), 32'h0);
    rstn = 1'b1; tick(2);

    send_frame(8'h45, 24'h123456, 1'b1);
    check("wr_count", 32'(we_cnt), 32'd1);
    check("wr_addr", 32'(coeff_addr), 32'h05);
    check("wr_wdata", 32'(coeff_wdata), 32'h123456);
    check("wr_latency", 32'(we_cyc - data_cyc), 32'd2);
    check("wr_err", 32'(err_cnt), 32'h0);
    check("wr_busy", 32'(busy), 32'h0);

    send_frame(8'h85, 24'h0, 1'b1);
    check("rd_count", 32'(load_cnt), 32'd1);
    check("rd_data", 32'(tx_data), 32'hABCDEF);
    check("rd_latency", 32'(load_cyc - cmd_cyc), 32'd3);
    check("rd_no_we", 32'(we_cnt), 32'd1);

    send_frame(8'hC0, 24'h000002, 1'b1);
    check("ctrl_value", 32'(ctrl), 32'h02);
    check("ctrl_no_commit", 32'(commit_cnt), 32'd0);

    send_frame(8'hFF, 24'h5A5A5A, 1'b1);
    check("commit_count", 32'(commit_cnt), 32'd1);
    check("commit_latency", 32'(commit_cyc - data_cyc), 32'd2);
    check("commit_ctrl", 32'(ctrl), 32'h02);

    send_frame(8'h45, 24'h999999, 1'b0);
    check("abort_no_we", 32'(we_cnt), 32'd1);
    check("abort_err", 32'(err_cnt), 32'd1);
    check("abort_busy", 32'(busy), 32'h0);

    send_frame(8'hC7, 24'h000003, 1'b1);
    check("illegal_err", 32'(err_cnt), 32'd2);
    check("illegal_ctrl", 32'(ctrl), 32'h02);
    check("illegal_commit", 32'(commit_cnt), 32'd1);

    send_frame(8'h00, 24'h111111, 1'b1);
    check("nop_err", 32'(err_cnt), 32'd2);
    check("nop_addr", 32'(coeff_addr), 32'h00);
    check("nop_strobes", 32'(we_cnt + load_cnt + commit_cnt), 32'd3);

    // data_rdy rise in the same cycle the frame ends
    frame_active = 1'b1; tick(2);
    rx_buf = {8'h4A, 24'hC0FFEE}; rx_cmd_rdy = 1'b1; tick(3);
    rx_data_rdy = 1'b1; frame_active = 1'b0; tick(4);
    rx_cmd_rdy = 1'b0; rx_data_rdy = 1'b0; tick(2);
    check("simul_we", 32'(we_cnt), 32'd2);
    check("simul_addr", 32'(coeff_addr), 32'h0A);
    check("simul_wdata", 32'(coeff_wdata), 32'hC0FFEE);
    check("simul_err", 32'(err_cnt), 32'd2);

    // long frame: second command byte must be ignored
    frame_active = 1'b1; tick(2);
    rx_buf = {8'h43, 24'h0000AA}; rx_cmd_rdy = 1'b1; tick(3);
    rx_data_rdy = 1'b1; tick(3);
    rx_cmd_rdy = 1'b0; rx_data_rdy = 1'b0; tick(2);
    rx_buf = {8'h47, 24'h0000BB}; rx_cmd_rdy = 1'b1; tick(3);
    rx_data_rdy = 1'b1; tick(3);
    frame_active = 1'b0; rx_cmd_rdy = 1'b0; rx_data_rdy = 1'b0; tick(3);
    check("long_we", 32'(we_cnt), 32'd3);
    check("long_addr", 32'(coeff_addr), 32'h03);
    check("long_wdata", 32'(coeff_wdata), 32'h0000AA);

    repeat (260) send_frame(8'h45, 24'h0, 1'b0);
    check("sat_err", 32'(err_cnt), 32'hFF);
    check("sat_no_we", 32'(we_cnt), 32'd3);

    // reset asserted while waiting for data of a WRITE frame
    frame_active = 1'b1; tick(2);
    rx_buf = {8'h45, 24'h777777}; rx_cmd_rdy = 1'b1; tick(3);
    rstn = 1'b0; tick(1);
    check("mid_rst_addr", 32'(coeff_addr), 32'h0);
    check("mid_rst_err", 32'(err_cnt), 32'h0);
    check("mid_rst_ctrl", 32'(ctrl), 32'h01);
    check("mid_rst_busy", 32'(busy), 32'h0);
    check("mid_rst_txdata", 32'(tx_data), 32'h0);
    rstn = 1'b1; tick(2);
    rx_data_rdy = 1'b1; tick(4);
    frame_active = 1'b0; rx_cmd_rdy = 1'b0; rx_data_rdy = 1'b0; tick(3);
    check("mid_rst_no_we", 32'(we_cnt), 32'd3);
    check("mid_rst_wdata", 32'(coeff_wdata), 32'h0);
    check("mid_rst_busy2", 32'(busy), 32'h0);

    send_frame(8'h4C, 24'h654321, 1'b1);
    check("post_rst_we", 32'(we_cnt), 32'd4);
    check("post_rst_addr", 32'(coeff_addr), 32'h0C);
    check("post_rst_wdata", 32'(coeff_wdata), 32'h654321);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
